// File: rtl/fft_stream_adapter.sv
// ---------------------------------------------------------------------------
// fft_stream_adapter
//
// Streaming wrapper for the parallel FFT cores (fft4/fft8/fft16). Serial
// complex samples arriving on a valid/ready stream are collected into a
// frame of N elements. Each full frame is presented in parallel to the core
// with a one-cycle `fft_next` pulse. The core's result frame is captured on
// `fft_next_out` and replayed as a serial valid/ready stream. Refilling the
// input buffer overlaps with core processing and with output draining. At
// most one frame is outstanding inside the core at any time.
//
// Parameters:
//   N            FFT points (4, 8 or 16)
//   W            width of each real / imaginary component
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   s_valid      input sample valid
//   s_ready      input sample accepted when s_valid && s_ready
//   s_r, s_i     real / imaginary part of the input sample
//   fft_in       parallel frame to the core; element k at
//                [(N-k)*2W-1 -: 2W], real part in the upper half
//   fft_next     one-cycle frame-start pulse to the core
//   fft_out      parallel result frame from the core, packed like fft_in
//   fft_next_out core frame-done strobe; fft_out valid in this cycle
//   m_valid      output sample valid
//   m_ready      downstream accepts the output sample
//   m_r, m_i     real / imaginary part of the output sample
//   m_last       marks output element N-1 of a frame
//   err          sticky: core completion seen with no frame outstanding
// ---------------------------------------------------------------------------
module fft_stream_adapter #(
    parameter int N = 8,
    parameter int W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_r,
    input  logic [W-1:0]     s_i,
    output logic [N*2*W-1:0] fft_in,
    output logic             fft_next,
    input  logic [N*2*W-1:0] fft_out,
    input  logic             fft_next_out,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W-1:0]     m_r,
    output logic [W-1:0]     m_i,
    output logic             m_last,
    output logic             err
);

    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [2*W-1:0] in_buf  [N];
    logic [2*W-1:0] out_buf [N];
    logic [CW-1:0]  wr_cnt;
    logic [CW-1:0]  rd_cnt;
    logic           in_full;
    logic           busy;
    logic           out_full;

    logic           in_hs;
    logic           out_hs;
    logic           issue;
    logic           capture;

    // s_ready is forced low while reset is held, even though in_full is
    // already clear, so nothing is accepted during reset.
    assign s_ready = reset && !in_full;
    assign in_hs   = s_valid && s_ready;
    assign out_hs  = out_full && m_ready;

    // A frame may only be issued when the core is idle and the previous
    // result has fully drained, so a capture can never overwrite out_buf
    // while it is still being read.
    assign issue   = in_full && !busy && !out_full;
    assign capture = fft_next_out && busy;

    // Present the input buffer directly to the core. It stays stable during
    // the fft_next cycle because refill writes land on the following edge.
    for (genvar k = 0; k < N; k++) begin : g_fft_in
        assign fft_in[(N-k)*2*W-1 -: 2*W] = in_buf[k];
    end

    // Input side: collect N samples, then hold the frame until it is issued.
    // A handshake and an issue are mutually exclusive because one needs
    // in_full low and the other needs it high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                in_buf[k] <= '0;
            end
            wr_cnt  <= '0;
            in_full <= 1'b0;
        end else begin
            if (in_hs) begin
                in_buf[wr_cnt] <= {s_r, s_i};
                if (wr_cnt == LAST) begin
                    wr_cnt  <= '0;
                    in_full <= 1'b1;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end else if (issue) begin
                in_full <= 1'b0;
            end
        end
    end

    // Core tracking: busy is set on issue so that a zero-latency core,
    // completing in the same cycle as fft_next, is still recognised.
    // A completion while idle is ignored apart from raising the sticky err.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fft_next <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            fft_next <= issue;
            if (issue) begin
                busy <= 1'b1;
            end else if (capture) begin
                busy <= 1'b0;
            end
            if (fft_next_out && !busy) begin
                err <= 1'b1;
            end
        end
    end

    // Output side: capture the whole result frame at once, then step through
    // it one element per accepted handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                out_buf[k] <= '0;
            end
            rd_cnt   <= '0;
            out_full <= 1'b0;
        end else begin
            if (capture) begin
                for (int k = 0; k < N; k++) begin
                    out_buf[k] <= fft_out[(N-k)*2*W-1 -: 2*W];
                end
                out_full <= 1'b1;
                rd_cnt   <= '0;
            end else if (out_hs) begin
                if (rd_cnt == LAST) begin
                    out_full <= 1'b0;
                    rd_cnt   <= '0;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end
        end
    end

    assign m_valid    = out_full;
    assign {m_r, m_i} = out_buf[rd_cnt];
    assign m_last     = out_full && (rd_cnt == LAST);

endmodule

// File: tb/tb_fft_stream_adapter.sv
// ---------------------------------------------------------------------------
// tb_fft_stream_adapter
//
// Bench for fft_stream_adapter. Two instances are built, N=4 for the directed
// steps and N=16 for the randomized streaming run; a select signal routes the
// shared stimulus to one of them and muxes its outputs back. The bench also
// plays the role of the FFT core. The core's transform is an arbitrary
// element-wise function; the reference model predicts each output frame from
// the accepted input samples and checks transport, ordering, framing and
// handshake behaviour.
// ---------------------------------------------------------------------------
module tb_fft_stream_adapter;

    localparam int W = 32;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            use16;
    int              cur_n;

    logic            sv;
    logic            mrdy;
    logic            fno;
    logic [W-1:0]    sr;
    logic [W-1:0]    si;
    logic [1023:0]   fout;

    logic            srdy4, fnext4, mv4, ml4, err4;
    logic [255:0]    fin4;
    logic [W-1:0]    mr4, mi4;

    logic            srdy16, fnext16, mv16, ml16, err16;
    logic [1023:0]   fin16;
    logic [W-1:0]    mr16, mi16;

    logic            srdy, fnext, mv, ml, err_m;
    logic [W-1:0]    mr, mi;

    int              compared   = 0;
    int              mismatched = 0;

    int              er[4] = '{10, -2, -2, -2};
    int              ei[4] = '{0, 2, 0, -2};

    always #5 clk = ~clk;

    fft_stream_adapter #(.N(4), .W(W)) dut4 (
        .clk          (clk),
        .reset        (reset_n),
        .s_valid      (sv && !use16),
        .s_ready      (srdy4),
        .s_r          (sr),
        .s_i          (si),
        .fft_in       (fin4),
        .fft_next     (fnext4),
        .fft_out      (fout[255:0]),
        .fft_next_out (fno && !use16),
        .m_valid      (mv4),
        .m_ready      (mrdy && !use16),
        .m_r          (mr4),
        .m_i          (mi4),
        .m_last       (ml4),
        .err          (err4)
    );

    fft_stream_adapter #(.N(16), .W(W)) dut16 (
        .clk          (clk),
        .reset        (reset_n),
        .s_valid      (sv && use16),
        .s_ready      (srdy16),
        .s_r          (sr),
        .s_i          (si),
        .fft_in       (fin16),
        .fft_next     (fnext16),
        .fft_out      (fout),
        .fft_next_out (fno && use16),
        .m_valid      (mv16),
        .m_ready      (mrdy && use16),
        .m_r          (mr16),
        .m_i          (mi16),
        .m_last       (ml16),
        .err          (err16)
    );

    assign srdy  = use16 ? srdy16  : srdy4;
    assign fnext = use16 ? fnext16 : fnext4;
    assign mv    = use16 ? mv16    : mv4;
    assign ml    = use16 ? ml16    : ml4;
    assign err_m = use16 ? err16   : err4;
    assign mr    = use16 ? mr16    : mr4;
    assign mi    = use16 ? mi16    : mi4;

    // Single comparison point: counts every check, reports and counts misses.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] fin_elem(input int k);
        if (use16) return fin16[(16-k)*64-1 -: 64];
        return fin4[(4-k)*64-1 -: 64];
    endfunction

    task automatic set_fout(input int k, input logic [63:0] v);
        fout[(cur_n-k)*64-1 -: 64] = v;
    endtask

    // The pretend core: output element k is derived from input element N-1-k.
    function automatic logic [63:0] core_fn(input logic [63:0] x, input int k);
        return {x[31:0] + 32'(k), x[63:32] - 32'd7};
    endfunction

    // Streams `frames` random frames through the selected DUT while acting as
    // the core with the given latency, and checks every cycle against the
    // counting model: handshakes accepted, frames issued, frames captured and
    // outputs consumed.
    task automatic applyStimulus(input int frames, input int valid_pct, input bit rand_ready,
                                 input int latency, input int budget);
        logic [63:0] to_send[$];
        logic [63:0] acc_q[$];
        logic [63:0] exp_q[$];
        logic [63:0] core_frame[16];
        logic [63:0] held;
        logic [63:0] e;
        bit          hold_pending = 0;
        bit          cap_pending  = 0;
        int          accepted = 0;
        int          issued   = 0;
        int          captured = 0;
        int          outputs  = 0;
        int          core_cnt = -1;
        int          total    = frames * cur_n;
        held = '0;
        for (int k = 0; k < total; k++) to_send.push_back({$urandom(), $urandom()});
        for (int cyc = 0; cyc < budget && outputs < total; cyc++) begin
            @(negedge clk);
            if (cap_pending) begin
                captured++;
                cap_pending = 0;
            end
            if (fnext) begin
                checkOutput("issue_after_drain", 64'(outputs), 64'(issued * cur_n));
                for (int k = 0; k < cur_n; k++) begin
                    core_frame[k] = fin_elem(k);
                    e = (issued * cur_n + k < acc_q.size()) ? acc_q[issued * cur_n + k] : 'x;
                    checkOutput("fft_in", core_frame[k], e);
                end
                issued++;
                core_cnt = latency;
            end
            checkOutput("s_ready", 64'(srdy), 64'((accepted / cur_n) == issued));
            checkOutput("m_valid", 64'(mv), 64'(captured * cur_n > outputs));
            if (hold_pending) checkOutput("hold", {mr, mi}, held);

            mrdy = rand_ready ? 1'($urandom_range(0, 1)) : (cyc % 2 == 0);
            if (mv && mrdy) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                checkOutput("m_data", {mr, mi}, e);
                checkOutput("m_last", 64'(ml), 64'((outputs % cur_n) == cur_n - 1));
                outputs++;
            end
            hold_pending = mv && !mrdy;
            held = {mr, mi};

            sv = (to_send.size() > 0) && (int'($urandom_range(0, 99)) < valid_pct);
            if (to_send.size() > 0) {sr, si} = to_send[0];
            if (sv && srdy) begin
                acc_q.push_back(to_send.pop_front());
                accepted++;
                if (accepted % cur_n == 0) begin
                    for (int k = 0; k < cur_n; k++)
                        exp_q.push_back(core_fn(acc_q[accepted - 1 - k], k));
                end
            end

            fno = 1'b0;
            if (core_cnt == 0) begin
                for (int k = 0; k < cur_n; k++) set_fout(k, core_fn(core_frame[cur_n - 1 - k], k));
                fno = 1'b1;
                cap_pending = 1;
                core_cnt = -1;
            end else if (core_cnt > 0) begin
                core_cnt--;
            end
        end
        @(negedge clk);
        sv   = 1'b0;
        fno  = 1'b0;
        mrdy = 1'b0;
        checkOutput("stream_complete", 64'(outputs), 64'(total));
    endtask

    initial begin
        reset_n = 1'b0;
        use16   = 1'b0;
        cur_n   = 4;
        sv      = 1'b0;
        mrdy    = 1'b0;
        fno     = 1'b0;
        sr      = '0;
        si      = '0;
        fout    = '0;

        // Reset state of both instances
        #2;
        checkOutput("rst_s_ready", 64'(srdy), 64'(0));
        checkOutput("rst_fft_next", 64'(fnext), 64'(0));
        checkOutput("rst_m_valid", 64'(mv), 64'(0));
        checkOutput("rst_m_last", 64'(ml), 64'(0));
        checkOutput("rst_err", 64'(err_m), 64'(0));
        checkOutput("rst_fft_in4", 64'(fin4 != '0), 64'(0));
        checkOutput("rst_m_data", {mr, mi}, 64'(0));
        checkOutput("rst_s_ready16", 64'(srdy16), 64'(0));
        checkOutput("rst_fft_in16", 64'(fin16 != '0), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;

        // N=4 frame streamed back to back, core idle
        for (int k = 0; k < 4; k++) begin
            sv = 1'b1;
            sr = 32'(k + 1);
            si = '0;
            #1;
            checkOutput("fill_s_ready", 64'(srdy), 64'(1));
            @(negedge clk);
        end
        sv = 1'b0;
        checkOutput("full_no_next", 64'(fnext), 64'(0));
        checkOutput("full_s_ready", 64'(srdy), 64'(0));
        @(negedge clk);
        checkOutput("next_pulse", 64'(fnext), 64'(1));
        for (int k = 0; k < 4; k++) checkOutput("next_fft_in", fin_elem(k), {32'(k + 1), 32'(0)});
        checkOutput("refill_ready", 64'(srdy), 64'(1));
        @(negedge clk);
        checkOutput("next_one_cycle", 64'(fnext), 64'(0));

        // Core returns its frame 5 cycles after fft_next, m_ready held high
        repeat (4) @(negedge clk);
        for (int k = 0; k < 4; k++) set_fout(k, {32'(er[k]), 32'(ei[k])});
        fno  = 1'b1;
        mrdy = 1'b1;
        @(negedge clk);
        fno = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput("drain_valid", 64'(mv), 64'(1));
            checkOutput("drain_data", {mr, mi}, {32'(er[k]), 32'(ei[k])});
            checkOutput("drain_last", 64'(ml), 64'(k == 3));
            @(negedge clk);
        end
        checkOutput("drain_done", 64'(mv), 64'(0));
        checkOutput("no_err", 64'(err_m), 64'(0));
        mrdy = 1'b0;

        // Completion with nothing outstanding
        for (int k = 0; k < 4; k++) set_fout(k, {$urandom(), $urandom()});
        fno = 1'b1;
        @(negedge clk);
        fno = 1'b0;
        checkOutput("spurious_err", 64'(err_m), 64'(1));
        checkOutput("spurious_no_valid", 64'(mv), 64'(0));
        checkOutput("spurious_buf_kept", {mr, mi}, {32'(10), 32'(0)});
        repeat (3) @(negedge clk);
        checkOutput("err_sticky", 64'(err_m), 64'(1));
        checkOutput("spurious_still_idle", 64'(mv), 64'(0));

        // Overlapped frames with m_ready toggling 1,0,1,0
        applyStimulus(3, 100, 1'b0, 3, 300);
        checkOutput("err_still_sticky", 64'(err_m), 64'(1));

        // Reset in the middle of a frame
        for (int k = 0; k < 2; k++) begin
            sv = 1'b1;
            sr = 32'(50 + k);
            si = 32'(60 + k);
            @(negedge clk);
        end
        sv = 1'b0;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_s_ready", 64'(srdy), 64'(0));
        checkOutput("midrst_fft_next", 64'(fnext), 64'(0));
        checkOutput("midrst_m_valid", 64'(mv), 64'(0));
        checkOutput("midrst_m_last", 64'(ml), 64'(0));
        checkOutput("midrst_err", 64'(err_m), 64'(0));
        checkOutput("midrst_fft_in", 64'(fin4 != '0), 64'(0));
        checkOutput("midrst_m_data", {mr, mi}, 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sv = 1'b1;
            sr = 32'(100 + k);
            si = 32'(200 + k);
            @(negedge clk);
        end
        sv = 1'b0;
        checkOutput("fresh_wait", 64'(fnext), 64'(0));
        @(negedge clk);
        checkOutput("fresh_next", 64'(fnext), 64'(1));
        for (int k = 0; k < 4; k++) checkOutput("fresh_fft_in", fin_elem(k), {32'(100 + k), 32'(200 + k)});
        @(negedge clk);
        checkOutput("fresh_single_next", 64'(fnext), 64'(0));

        // N=16, random data and handshakes, zero-latency core
        use16 = 1'b1;
        cur_n = 16;
        @(negedge clk);
        applyStimulus(3, 50, 1'b1, 0, 2000);
        checkOutput("n16_no_err", 64'(err_m), 64'(0));
        checkOutput("n16_idle", 64'(mv), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fft_stream_adapter.md
# fft_stream_adapter

Streaming front/back end for the parallel FFT cores (`fft4`/`fft8`/`fft16`). It collects N serial complex samples from a valid/ready stream, presents them as one parallel frame on the core's `in[]` bus with a single-cycle `next` pulse, captures the core's `out[]` frame on `next_out`, and replays it as a serial valid/ready stream. Input filling overlaps with core processing and output draining. At most one frame is in flight inside the core.

## Interface

Parameters:
- `N`, default 8: FFT points. Legal values are 4, 8 and 16.
- `W`, default 32: width of each real and imaginary component, matching `complex_t`.

Ports:
- `clk`, input, 1: clock; all logic is rising-edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `s_valid`, input, 1: input sample valid.
- `s_ready`, output, 1: input sample accepted when `s_valid && s_ready`.
- `s_r`, input, W: real part of the input sample.
- `s_i`, input, W: imaginary part of the input sample.
- `fft_in`, output, N*2W: packed `complex_t` array driven to the core `in[0:N-1]`; element k is at bits `[(N-k)*2W-1 -: 2W]`, with r in the upper half.
- `fft_next`, output, 1: one-cycle frame-start pulse to the core `next`.
- `fft_out`, input, N*2W: core `out[0:N-1]`, packed the same way as `fft_in`.
- `fft_next_out`, input, 1: core frame-done strobe; `fft_out` is valid in this cycle.
- `m_valid`, output, 1: output sample valid.
- `m_ready`, input, 1: downstream accepts the output sample.
- `m_r`, output, W: real part of the output sample.
- `m_i`, output, W: imaginary part of the output sample.
- `m_last`, output, 1: marks output element N-1.
- `err`, output, 1: sticky flag; `fft_next_out` arrived with no frame outstanding.

## Operation

- State registers:
  - `in_buf[0:N-1]`, `wr_cnt`, `in_full`: input side.
  - `busy`: a frame is outstanding in the core.
  - `out_buf[0:N-1]`, `rd_cnt`, `out_full`: output side.
- Input side (FILL/FULL):
  - `s_ready = !in_full` while `reset` is high; `s_ready` is 0 while `reset` is low.
  - On an input handshake, write `{s_r, s_i}` to `in_buf[wr_cnt]` and increment `wr_cnt`.
  - On the handshake at `wr_cnt == N-1`, set `in_full` and wrap `wr_cnt` to 0.
- Issue (core IDLE→BUSY):
  - Condition: `in_full && !busy && !out_full` at a clock edge.
  - At that edge: `fft_next <= 1`, `busy <= 1`, `in_full <= 0`.
  - `fft_next` is registered and returns to 0 at the next edge.
  - `fft_in` is driven directly from `in_buf` and is stable throughout the `fft_next` cycle. Refill writes land at the end of that cycle at the earliest.
- Capture (core BUSY→IDLE):
  - Condition: an edge with `fft_next_out && busy`.
  - At that edge: `out_buf <= fft_out`, `out_full <= 1`, `rd_cnt <= 0`, `busy <= 0`.
- Unexpected completion: `fft_next_out` with `!busy` is ignored and sets `err <= 1`. `err` is cleared only by reset.
- Output side (DRAIN):
  - `m_valid = out_full`.
  - `{m_r, m_i} = out_buf[rd_cnt]`.
  - `m_last = out_full && rd_cnt == N-1`.
  - On an output handshake, increment `rd_cnt`. On the handshake where `m_last` is high, clear `out_full` and set `rd_cnt` to 0.
- Simultaneous events:
  - Capture and an input handshake in the same cycle are independent.
  - An issue cannot coincide with a drain handshake from the same frame, because issue requires `!out_full` at the edge. The earliest issue is the edge after the last output handshake.
- Output data is held stable while `m_valid && !m_ready`.

## Timing

- Reset values (asynchronous, reset low):
  - Counters and flags: `wr_cnt`, `rd_cnt`, `in_full`, `busy`, `out_full` are 0.
  - Outputs: `fft_next`, `m_valid`, `m_last`, `err`, `s_ready` are 0.
  - Buffers: `in_buf` and `out_buf` are 0, so `fft_in`, `m_r` and `m_i` are 0.
- Reset asserted mid-frame discards partial input, in-flight and draining frames. A later `fft_next_out` for the discarded frame sets `err`.
- Last input handshake at edge k: `in_full` is high in cycle k+1. `fft_next` is high in cycle k+2 at the earliest, i.e. one edge after `in_full` when the core is idle and the output buffer is empty.
- `fft_next_out` sampled at edge c gives `m_valid` high from cycle c+1. The first output appears one cycle after core completion.
- With `m_ready` held high, N outputs take N consecutive cycles.
- A core with zero latency, asserting `fft_next_out` in the same cycle as `fft_next`, is accepted, because `busy` is already 1 in that cycle.
- Steady-state throughput is one frame per max(N, core latency + N + 2) cycles.

## Test plan

- N=4, samples (1,0), (2,0), (3,0), (4,0) streamed back to back with core idle:
  - `fft_next` high exactly one cycle, 2 cycles after the 4th handshake.
  - `fft_in` elements equal (1,0)…(4,0) during that cycle.
- Core model returns `fft_out` = (10,0), (-2,2), (-2,0), (-2,-2) with `fft_next_out` 5 cycles after `fft_next`, `m_ready` = 1:
  - Outputs in that order on 4 consecutive cycles starting the cycle after `fft_next_out`.
  - `m_last` high only on (-2,-2).
- Second frame fully loaded while the first is still draining with `m_ready` toggling 1,0,1,0:
  - `s_ready` drops after 4 inputs.
  - `fft_next` for frame 2 fires only after frame 1's `m_last` handshake.
  - No output sample is dropped or repeated, and values are held while `m_ready`=0.
- `fft_next_out` pulsed with no frame issued:
  - `err` becomes 1 and stays 1.
  - `m_valid` stays 0.
  - `out_buf` is unchanged.
- `reset` pulsed low after 2 of 4 inputs:
  - All outputs are 0 immediately.
  - After release, 4 fresh inputs produce one `fft_next` carrying only the fresh data.
- N=16, 3 frames with random data, `s_valid` and `m_ready` randomly 50%:
  - The output stream matches the reference-model output frame by frame.
  - `m_last` asserts every 16th output.
